fixed_point_unit_seq: RTL and testbench
=======================================

Name: fixed_point_unit_seq

Overview:
- Parametrised, fully sequential successor to the team's fixed-point unit.
- Performs signed Qm.FBITS add, subtract, multiply and square root behind a start/busy/ready handshake.
- Adds saturation and an overflow/invalid flag.
- Multiply is a serial shift-add datapath and square root is a restoring digit-by-digit datapath, both iterative.

Parameters:
- WIDTH, 32, operand/result width in bits, two's complement; minimum 8.
- FBITS, 10, number of fraction bits; WIDTH+FBITS must be even, checked at elaboration.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when busy=0
- operation  input  2  00 ADD, 01 SUB, 10 MUL, 11 SQRT; sampled at accept
- operand_1  input  WIDTH  first operand, signed Q format; sampled at accept
- operand_2  input  WIDTH  second operand, signed Q format; sampled at accept; ignored for SQRT
- result  output  WIDTH  registered result; held until the next completion
- ready  output  1  single-cycle pulse; result and overflow are valid in the same cycle
- busy  output  1  high while an iterative operation is running
- overflow  output  1  saturation or invalid input for the last result; updated with ready

Behaviour:
- Reset: reset_n=0 asynchronously forces result=0, ready=0, busy=0, overflow=0, state=IDLE and clears all counters and working registers. This applies mid-operation: the operation is aborted and no ready pulse is produced.
- Accept: at a rising edge with start=1 and busy=0, the unit latches operation and operands. While busy=1, start is ignored and latched operands are not disturbed.
- Back-to-back: start may be asserted in the same cycle that ready is high.
- States: IDLE, MUL, SQRT.
- ADD/SUB: stay in IDLE. Compute with one guard bit; saturate to 0x7FF..F or 0x800..0 and set overflow=1 when saturated. Latency 1: ready is high in the cycle after the accept edge. busy stays 0.
- MUL: IDLE->MUL.
  - Take operand magnitudes; run WIDTH shift-add iterations, one bit of the multiplier per cycle, into a 2*WIDTH accumulator.
  - Apply the sign; arithmetic right shift by FBITS (truncation toward minus infinity).
  - If the value does not fit WIDTH signed bits, saturate and set overflow=1.
  - Latency WIDTH+1: busy=1 for WIDTH cycles; result, ready and overflow are registered on the edge that returns to IDLE.
- SQRT, negative operand_1: result=0, overflow=1, latency 1, no transition to SQRT.
- SQRT, otherwise: IDLE->SQRT.
  - Radicand = operand_1 << FBITS, width WIDTH+FBITS.
  - Run (WIDTH+FBITS)/2 iterations. Each iteration brings down 2 radicand bits, trial-subtracts (root<<2)|1 from the remainder and shifts in a 1 if the remainder is non-negative, else 0.
  - result = floor(sqrt(operand_1 * 2^FBITS)), which is the root in the same Q format; overflow=0.
  - Latency (WIDTH+FBITS)/2 + 1.
- Iteration counter: counts down to 0 and is zero in IDLE; the final iteration edge returns to IDLE.
- Result holding: result and overflow hold their value until the next ready pulse; they are never driven to X or Z.
- Operands: operands changing after accept must not affect the running result.

Test Plan:
- ADD 0x00000600 (1.5) + 0x00000400 (1.0) -> ready 1 cycle later, result 0x00000A00, overflow=0. ADD 0x7FFFFFFF + 1 -> result 0x7FFFFFFF, overflow=1.
- MUL 1536 (1.5) x 2048 (2.0) -> busy for 32 cycles, ready at cycle 33, result 3072. MUL -1536 x 2048 -> result 0xFFFFF400. MUL 0x7FFFFFFF x 0x7FFFFFFF -> result 0x7FFFFFFF, overflow=1.
- SQRT 4096 (4.0) -> ready at cycle 22, result 2048. SQRT 2048 (2.0) -> result 1448. SQRT 0 -> result 0. SQRT 0xFFFFFC00 (-1.0) -> ready after 1 cycle, result 0, overflow=1.
- Start MUL, pulse start with SUB at cycle 5 while busy -> SUB ignored; single ready at cycle 33 with the MUL result. Then issue SUB in the ready cycle -> its result appears 1 cycle later.
- Start SQRT, drop reset_n at cycle 10 -> busy, ready, result and overflow go to 0 immediately with no later ready pulse. After release, ADD 1+1 -> result 2.
- Change operand_1/operand_2 every cycle during a MUL of 1024 x 1024 -> result 1024 unchanged.

Source files
------------

// File: rtl/fixed_point_unit_seq.sv
// Sequential signed fixed-point unit: saturating add/sub in one cycle, plus an iterative
// shift-add multiply and a restoring square root behind a start/busy/ready handshake.
module fixed_point_unit_seq #(
    parameter int WIDTH = 32,
    parameter int FBITS = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       operation,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic [WIDTH-1:0] result,
    output logic             ready,
    output logic             busy,
    output logic             overflow
);

    localparam int RADW  = WIDTH + FBITS;
    localparam int ROOTW = RADW / 2;
    localparam int REMW  = ROOTW + 2;
    localparam int CW    = $clog2(RADW + 1);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH < 8) begin : g_width_check
        $error("fixed_point_unit_seq: WIDTH must be at least 8");
    end
    if ((WIDTH + FBITS) % 2 != 0) begin : g_parity_check
        $error("fixed_point_unit_seq: WIDTH+FBITS must be even");
    end

    typedef enum logic [1:0] {IDLE, MUL, SQRT} state_t;

    state_t                 state;
    logic [CW-1:0]          count;
    logic [WIDTH-1:0]       mcand;
    logic [2*WIDTH-1:0]     prod;
    logic                   neg;
    logic [RADW-1:0]        rad;
    logic [REMW-1:0]        rem;
    logic [ROOTW-1:0]       root;

    logic [WIDTH:0]         addsub_sum;
    logic                   addsub_ovf;
    logic [WIDTH-1:0]       addsub_val;
    logic [WIDTH-1:0]       op1_mag;
    logic [WIDTH-1:0]       op2_mag;

    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     prod_next;
    logic signed [2*WIDTH-1:0] prod_signed;
    logic [2*WIDTH-1:0]     prod_shift;
    logic                   mul_ovf;
    logic [WIDTH-1:0]       mul_val;

    logic [REMW+1:0]        rem_sh;
    logic [REMW+1:0]        trial;
    logic                   ge;
    logic [REMW-1:0]        rem_next;
    logic [ROOTW-1:0]       root_next;
    logic [ROOTW+WIDTH-1:0] root_ext;
    logic                   sqrt_ovf;
    logic [WIDTH-1:0]       sqrt_val;

    // Single-cycle add/sub with one guard bit, clamped on signed overflow.
    always_comb begin
        addsub_sum = operation[0] ? ({operand_1[WIDTH-1], operand_1} - {operand_2[WIDTH-1], operand_2})
                                  : ({operand_1[WIDTH-1], operand_1} + {operand_2[WIDTH-1], operand_2});
        addsub_ovf = addsub_sum[WIDTH] ^ addsub_sum[WIDTH-1];
        addsub_val = addsub_ovf ? (addsub_sum[WIDTH] ? MIN_NEG : MAX_POS) : addsub_sum[WIDTH-1:0];
        op1_mag    = operand_1[WIDTH-1] ? -operand_1 : operand_1;
        op2_mag    = operand_2[WIDTH-1] ? -operand_2 : operand_2;
    end

    // One multiplier bit per cycle: the low half of prod holds the remaining multiplier bits.
    always_comb begin
        mul_sum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_next   = {mul_sum, prod[WIDTH-1:1]};
        prod_signed = neg ? -prod_next : prod_next;
        prod_shift  = prod_signed >>> FBITS;
        mul_ovf     = !((&prod_shift[2*WIDTH-1:WIDTH-1]) || !(|prod_shift[2*WIDTH-1:WIDTH-1]));
        mul_val     = mul_ovf ? (prod_signed[2*WIDTH-1] ? MIN_NEG : MAX_POS) : prod_shift[WIDTH-1:0];
    end

    // Restoring square root step: bring down two radicand bits, trial-subtract (root<<2)|1.
    always_comb begin
        rem_sh    = {rem, rad[RADW-1:RADW-2]};
        trial     = {2'b00, root, 2'b01};
        ge        = rem_sh >= trial;
        rem_next  = REMW'(ge ? rem_sh - trial : rem_sh);
        root_next = {root[ROOTW-2:0], ge};
        root_ext  = {{WIDTH{1'b0}}, root_next};
        sqrt_ovf  = |root_ext[ROOTW+WIDTH-1:WIDTH-1];
        sqrt_val  = sqrt_ovf ? MAX_POS : root_ext[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= '0;
            mcand    <= '0;
            prod     <= '0;
            neg      <= 1'b0;
            rad      <= '0;
            rem      <= '0;
            root     <= '0;
            result   <= '0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !busy) begin
                        case (operation)
                            2'b00, 2'b01: begin
                                result   <= addsub_val;
                                overflow <= addsub_ovf;
                                ready    <= 1'b1;
                            end
                            2'b10: begin
                                mcand <= op1_mag;
                                prod  <= {{WIDTH{1'b0}}, op2_mag};
                                neg   <= operand_1[WIDTH-1] ^ operand_2[WIDTH-1];
                                count <= CW'(WIDTH);
                                busy  <= 1'b1;
                                state <= MUL;
                            end
                            default: begin
                                if (operand_1[WIDTH-1]) begin
                                    result   <= '0;
                                    overflow <= 1'b1;
                                    ready    <= 1'b1;
                                end else begin
                                    rad   <= RADW'(operand_1) << FBITS;
                                    rem   <= '0;
                                    root  <= '0;
                                    count <= CW'(ROOTW);
                                    busy  <= 1'b1;
                                    state <= SQRT;
                                end
                            end
                        endcase
                    end
                end
                MUL: begin
                    prod  <= prod_next;
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        result   <= mul_val;
                        overflow <= mul_ovf;
                        ready    <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                SQRT: begin
                    rad   <= rad << 2;
                    rem   <= rem_next;
                    root  <= root_next;
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        result   <= sqrt_val;
                        overflow <= sqrt_ovf;
                        ready    <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_unit_seq.sv
// Directed self-checking bench for fixed_point_unit_seq with hand-computed Q21.10 expectations.
module tb_fixed_point_unit_seq;

    localparam int WIDTH    = 32;
    localparam int FBITS    = 10;
    localparam int MUL_LAT  = WIDTH + 1;
    localparam int SQRT_LAT = (WIDTH + FBITS) / 2 + 1;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_SQRT = 2'b11;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [1:0]       operation;
    logic [WIDTH-1:0] operand_1;
    logic [WIDTH-1:0] operand_2;
    logic [WIDTH-1:0] result;
    logic             ready;
    logic             busy;
    logic             overflow;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fixed_point_unit_seq #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .operation (operation),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .result    (result),
        .ready     (ready),
        .busy      (busy),
        .overflow  (overflow)
    );

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
        end
    endtask

    // Drives one request for a single clock edge; returns one time unit after the accept edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
        start     = 1'b1;
        operation = op;
        operand_1 = a;
        operand_2 = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitReady(output int cycles);
        cycles = 1;
        while (!ready && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic runOp(input string tag, input logic [1:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_result,
                         input logic exp_ovf, input int exp_lat);
        int lat;
        applyStimulus(op, a, b);
        waitReady(lat);
        checkOutput({tag, " ready"}, WIDTH'(ready), 1);
        checkOutput({tag, " latency"}, WIDTH'(lat), WIDTH'(exp_lat));
        checkOutput({tag, " result"}, result, exp_result);
        checkOutput({tag, " overflow"}, WIDTH'(overflow), WIDTH'(exp_ovf));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached before summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int ready_seen;

        reset_n   = 1'b0;
        start     = 1'b0;
        operation = OP_ADD;
        operand_1 = '0;
        operand_2 = '0;
        #2;
        checkOutput("reset result", result, 0);
        checkOutput("reset ready", WIDTH'(ready), 0);
        checkOutput("reset busy", WIDTH'(busy), 0);
        checkOutput("reset overflow", WIDTH'(overflow), 0);
        #10;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        runOp("add 1.5+1.0", OP_ADD, 32'h0000_0600, 32'h0000_0400, 32'h0000_0A00, 1'b0, 1);
        runOp("add sat pos", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1);
        runOp("sub 1.0-1.5", OP_SUB, 32'h0000_0400, 32'h0000_0600, 32'hFFFF_FE00, 1'b0, 1);
        runOp("sub sat neg", OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b1, 1);

        applyStimulus(OP_MUL, 32'd1536, 32'd2048);
        checkOutput("mul busy after accept", WIDTH'(busy), 1);
        waitReady(n);
        checkOutput("mul 1.5x2 latency", WIDTH'(n), WIDTH'(MUL_LAT));
        checkOutput("mul 1.5x2 result", result, 32'd3072);
        checkOutput("mul 1.5x2 overflow", WIDTH'(overflow), 0);
        checkOutput("mul busy at ready", WIDTH'(busy), 0);

        runOp("mul -1.5x2", OP_MUL, 32'hFFFF_FA00, 32'd2048, 32'hFFFF_F400, 1'b0, MUL_LAT);
        runOp("mul sat pos", OP_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, MUL_LAT);
        runOp("mul sat neg", OP_MUL, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, MUL_LAT);
        runOp("mul floor neg lsb", OP_MUL, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, MUL_LAT);
        runOp("mul floor pos lsb", OP_MUL, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0, MUL_LAT);

        runOp("sqrt 4.0", OP_SQRT, 32'd4096, 32'h0, 32'd2048, 1'b0, SQRT_LAT);
        runOp("sqrt 2.0", OP_SQRT, 32'd2048, 32'h0, 32'd1448, 1'b0, SQRT_LAT);
        runOp("sqrt 0", OP_SQRT, 32'd0, 32'h0, 32'd0, 1'b0, SQRT_LAT);
        runOp("sqrt -1.0", OP_SQRT, 32'hFFFF_FC00, 32'h0, 32'd0, 1'b1, 1);
        checkOutput("sqrt neg busy", WIDTH'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold result", result, 32'd0);
        checkOutput("hold overflow", WIDTH'(overflow), 1);
        checkOutput("hold ready low", WIDTH'(ready), 0);

        // A SUB request raised mid-multiply must be ignored entirely.
        applyStimulus(OP_MUL, 32'd1536, 32'd2048);
        n = 1;
        while (!ready && n < 100) begin
            if (n == 4) begin
                start     = 1'b1;
                operation = OP_SUB;
                operand_1 = 32'h0000_0600;
                operand_2 = 32'h0000_0400;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        checkOutput("busy ignore latency", WIDTH'(n), WIDTH'(MUL_LAT));
        checkOutput("busy ignore result", result, 32'd3072);
        runOp("back-to-back sub", OP_SUB, 32'h0000_0600, 32'h0000_0400, 32'h0000_0200, 1'b0, 1);
        @(posedge clk);
        #1;
        checkOutput("single ready pulse", WIDTH'(ready), 0);

        applyStimulus(OP_MUL, 32'd1024, 32'd1024);
        n = 1;
        while (!ready && n < 100) begin
            operand_1 = $urandom;
            operand_2 = $urandom;
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("scramble latency", WIDTH'(n), WIDTH'(MUL_LAT));
        checkOutput("scramble result", result, 32'd1024);

        runOp("pre-abort add sat", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1);
        applyStimulus(OP_SQRT, 32'd4096, 32'h0);
        n = 1;
        while (n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("abort busy before reset", WIDTH'(busy), 1);
        reset_n = 1'b0;
        #1;
        checkOutput("abort busy", WIDTH'(busy), 0);
        checkOutput("abort ready", WIDTH'(ready), 0);
        checkOutput("abort result", result, 32'd0);
        checkOutput("abort overflow", WIDTH'(overflow), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        ready_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (ready) ready_seen++;
        end
        checkOutput("abort no late ready", WIDTH'(ready_seen), 0);
        runOp("post-reset add", OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
